// File: rtl/ddr3_req_queue_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_req_queue_pkg
// Shared DDR3 parameters: device geometry, host address split widths, BL8
// burst data/mask widths, and the queue entry layout used by the request
// queue and its open-row table.
// ----------------------------------------------------------------------------
package ddr3_req_queue_pkg;

  // Device parameters (x16 part, 8 banks, BL8)
  localparam int unsigned DDR3_DQ_W      = 16;
  localparam int unsigned DDR3_BURST_LEN = 8;
  localparam int unsigned DDR3_NUM_BANKS = 8;

  // Host address split: {row, bank, column}
  localparam int unsigned DDR3_ROW_BITS  = 13;
  localparam int unsigned BANK_BITS      = 3;
  localparam int unsigned COL_BITS       = 10;
  // Row field as presented to the controller (rows are zero-extended to this)
  localparam int unsigned ROW_OUT_W      = 14;

  // One BL8 burst worth of data and its byte mask
  localparam int unsigned BL8_DATA_W     = DDR3_BURST_LEN * DDR3_DQ_W;
  localparam int unsigned BL8_MASK_W     = BL8_DATA_W / 8;

  typedef logic [ROW_OUT_W-1:0]  row_t;
  typedef logic [BANK_BITS-1:0]  bank_t;
  typedef logic [COL_BITS-1:0]   col_t;
  typedef logic [BL8_DATA_W-1:0] wdata_t;
  typedef logic [BL8_MASK_W-1:0] wmask_t;

  // One queued command
  typedef struct packed {
    logic   write;
    bank_t  ba;
    row_t   row;
    col_t   col;
    wdata_t wdata;
    wmask_t wmask;
  } req_entry_t;

endpackage

// File: rtl/ddr3_req_queue_open_row_table.sv
// ----------------------------------------------------------------------------
// ddr3_open_row_table
// Tracks, per bank, whether a row is open and which one. A command transfer
// opens its row in its bank; PRECHARGE ALL closes every bank, except that a
// transfer on the same edge still opens its own bank.
// Ports:
//   clk, rst_n        clock, async active-low reset (open bits only)
//   upd_en/ba/row     command transfer: mark {ba} open with {row}
//   clr_all           PRECHARGE ALL issued this edge
//   lkp_en/ba/row     lookup qualifier, bank and row of the head command
//   lkp_hit           lkp_en && open[lkp_ba] && row[lkp_ba] == lkp_row
// ----------------------------------------------------------------------------
module ddr3_open_row_table
  import ddr3_req_queue_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  upd_en,
  input  bank_t upd_ba,
  input  row_t  upd_row,
  input  logic  clr_all,
  input  logic  lkp_en,
  input  bank_t lkp_ba,
  input  row_t  lkp_row,
  output logic  lkp_hit
);

  logic [DDR3_NUM_BANKS-1:0] open_q, open_d;
  row_t                      row_q [DDR3_NUM_BANKS];
  row_t                      row_d [DDR3_NUM_BANKS];

  // Next-state of the table: the update for its own bank takes priority over the clear
  always_comb begin
    open_d = '0;
    for (int i = 0; i < DDR3_NUM_BANKS; i++) begin
      row_d[i]  = (upd_en && (upd_ba == BANK_BITS'(i))) ? upd_row : row_q[i];
      open_d[i] = (upd_en && (upd_ba == BANK_BITS'(i))) ? 1'b1
                : (clr_all ? 1'b0 : open_q[i]);
    end
  end

  // Open bits: reset to all banks closed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
    end else begin
      open_q <= open_d;
    end
  end

  // Row storage: only meaningful while the matching open bit is set, so no reset
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  assign lkp_hit = lkp_en && open_q[lkp_ba] && (row_q[lkp_ba] == lkp_row);

endmodule

// File: rtl/ddr3_req_queue.sv
// ----------------------------------------------------------------------------
// ddr3_req_queue
// DEPTH-entry FIFO of host read/write requests in front of a DDR3 controller.
// The head entry is presented from registered storage together with a row-hit
// flag taken from the per-bank open-row table.
// Ports:
//   clk, rst_n                 controller clock, async active-low reset
//   req_valid/ready            host request handshake
//   req_write/addr/wdata/wmask request: addr = {row, bank[2:0], col[9:0]}
//   cmd_valid/ready            controller handshake for the head entry
//   cmd_write/ba/row/col/...   head entry fields (row zero-extended to 14 bits)
//   cmd_row_hit                head row is the row currently open in cmd_ba
//   pre_all                    controller issued PRECHARGE ALL
//   count                      occupied entries, 0..DEPTH
// ----------------------------------------------------------------------------
module ddr3_req_queue
  import ddr3_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROW_BITS = DDR3_ROW_BITS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [ROW_BITS+BANK_BITS+COL_BITS-1:0] req_addr,
  input  logic [BL8_DATA_W-1:0]                 req_wdata,
  input  logic [BL8_MASK_W-1:0]                 req_wmask,
  output logic                                  cmd_valid,
  input  logic                                  cmd_ready,
  output logic                                  cmd_write,
  output logic [BANK_BITS-1:0]                  cmd_ba,
  output logic [ROW_OUT_W-1:0]                  cmd_row,
  output logic [COL_BITS-1:0]                   cmd_col,
  output logic [BL8_DATA_W-1:0]                 cmd_wdata,
  output logic [BL8_MASK_W-1:0]                 cmd_wmask,
  output logic                                  cmd_row_hit,
  input  logic                                  pre_all,
  output logic [$clog2(DEPTH):0]                count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  req_entry_t       mem_q [DEPTH];
  req_entry_t       wr_entry_d;
  req_entry_t       head;
  logic             push;
  logic             pop;

  // Handshake flags depend only on the registered count, never on cmd_ready
  assign req_ready = (count_q != FULL_CNT);
  assign cmd_valid = (count_q != {CNT_W{1'b0}});
  assign count     = count_q;

  assign push = req_valid && req_ready;
  assign pop  = cmd_valid && cmd_ready;

  // Split the host address into entry fields; the row is zero-extended
  always_comb begin
    wr_entry_d       = '0;
    wr_entry_d.write = req_write;
    wr_entry_d.col   = req_addr[COL_BITS-1:0];
    wr_entry_d.ba    = req_addr[COL_BITS +: BANK_BITS];
    wr_entry_d.row   = ROW_OUT_W'(req_addr[COL_BITS+BANK_BITS +: ROW_BITS]);
    wr_entry_d.wdata = req_wdata;
    wr_entry_d.wmask = req_wmask;
  end

  // Pointer and occupancy next-state; pointers wrap naturally as DEPTH is a power of two
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: never reset, contents are only visible behind cmd_valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign cmd_write = head.write;
  assign cmd_ba    = head.ba;
  assign cmd_row   = head.row;
  assign cmd_col   = head.col;
  assign cmd_wdata = head.wdata;
  assign cmd_wmask = head.wmask;

  // Hit looks at the head only; the lookup is gated so it reads 0 when empty
  ddr3_open_row_table u_open_rows (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd_en  (pop),
    .upd_ba  (head.ba),
    .upd_row (head.row),
    .clr_all (pre_all),
    .lkp_en  (cmd_valid),
    .lkp_ba  (head.ba),
    .lkp_row (head.row),
    .lkp_hit (cmd_row_hit)
  );

endmodule
